// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: instruction-memory request/response, redirect and decode handshakes.
// master = fetch_queue side, slave = memory/decode/branch environment side.
interface fetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
  logic        empty;
  logic        full;

  modport master (
    output imem_req, imem_addr, dec_valid, dec_pc, dec_instr, empty, full,
    input  imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_req, imem_addr, dec_valid, dec_pc, dec_instr, empty, full,
    output imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, dec_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential fetch, in-order response FIFO, redirect flush/drain.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_queue_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic [0:0]    state_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   resp_pc_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] outstanding_q;
  logic [CW-1:0] stale_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  entry_t        mem_q [DEPTH];

  logic          run;
  logic          rsp_ok;
  logic [CW:0]   in_use;
  logic          can_issue;
  logic          accept;
  logic          fifo_empty;
  logic          bypass;
  logic          bypass_take;
  logic          pop;
  logic          push;
  logic          resp_adv;
  logic [CW-1:0] out_next;
  logic [31:0]   target;
  entry_t        head;

  assign run        = (state_q == RUN);
  assign fifo_empty = (count_q == '0);
  assign target     = bus.redirect_pc & ~32'h3;

  // Responses with nothing outstanding are protocol errors and are ignored everywhere.
  assign rsp_ok = bus.imem_rvalid && (outstanding_q != '0);

  // Credit rule: never let queued plus in-flight entries exceed the FIFO, so every response lands.
  assign in_use    = {1'b0, count_q} + {1'b0, outstanding_q};
  assign can_issue = (in_use < {1'b0, DEPTH_C}) && (outstanding_q < MAX_OUT_C);

  assign bus.imem_req  = reset && run && !bus.redirect && can_issue;
  assign bus.imem_addr = fetch_pc_q;
  assign accept        = bus.imem_req && bus.imem_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = fifo_empty && run && !bus.redirect && rsp_ok;
`else
  assign bypass = 1'b0;
`endif

  assign head          = mem_q[rd_ptr_q];
  assign bus.dec_valid = !fifo_empty || bypass;
  assign pop           = !fifo_empty && bus.dec_ready;
  assign bypass_take   = bypass && bus.dec_ready;

  // NOTE: the FIFO storage is never reset, so head data is forced to zero whenever the FIFO is empty.
  always_comb begin
    bus.dec_pc    = '0;
    bus.dec_instr = '0;
    if (!fifo_empty) begin
      bus.dec_pc    = head.pc;
      bus.dec_instr = head.instr;
    end else if (bypass) begin
      bus.dec_pc    = resp_pc_q;
      bus.dec_instr = bus.imem_rdata;
    end
  end

  assign bus.empty = fifo_empty;
  assign bus.full  = (count_q == DEPTH_C);

  assign resp_adv = run && rsp_ok && !bus.redirect;
  assign push     = resp_adv && !bypass_take;
  assign out_next = outstanding_q + CW'(accept) - CW'(rsp_ok);

  // NOTE: all state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      stale_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else if (bus.redirect) begin
      // Every request still in flight after this edge belongs to the abandoned path.
      outstanding_q <= out_next;
      stale_q       <= out_next;
      state_q       <= (out_next != '0) ? DRAIN : RUN;
      fetch_pc_q    <= target;
      resp_pc_q     <= target;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      outstanding_q <= out_next;
      count_q       <= count_q + CW'(push) - CW'(pop);
      if (accept)   fetch_pc_q <= fetch_pc_q + 32'd4;
      if (resp_adv) resp_pc_q  <= resp_pc_q + 32'd4;
      if (push)     wr_ptr_q   <= wr_ptr_q + 1'b1;
      if (pop)      rd_ptr_q   <= rd_ptr_q + 1'b1;
      if (state_q == DRAIN) begin
        if (stale_q == '0) begin
          state_q <= RUN;
        end else if (rsp_ok) begin
          stale_q <= stale_q - 1'b1;
          if (stale_q == CW'(1)) state_q <= RUN;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{pc: resp_pc_q, instr: bus.imem_rdata};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized self-checking bench for fetch_queue against a queue-based reference model.
// The model tracks each issued request by address and flags requests abandoned by a redirect.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    int          issued;
    bit          stale;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  fetch_queue_if bus();

  fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  req_t        inflight[$];
  ent_t        fifo[$];
  logic [31:0] fetch_pc;
  int          cyc;
  int          n_checks;
  int          n_pass;
  int          decoded;

  int          p_ready, p_rsp, p_dec, p_redir;
  bit          bogus, f_redir;
  logic [31:0] f_pc;

  bit          m_req, m_dec_valid;
  logic        obs_valid;
  logic [31:0] obs_pc;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_0000;
  endfunction

  task automatic model_reset();
    inflight.delete();
    fifo.delete();
    fetch_pc = RESET_PC;
  endtask

  task automatic drive_idle();
    bus.imem_ready  = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.dec_ready   = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req"},   {31'd0, bus.imem_req},  32'd0);
    check({tag, "_addr"},  bus.imem_addr,          RESET_PC);
    check({tag, "_dv"},    {31'd0, bus.dec_valid}, 32'd0);
    check({tag, "_pc"},    bus.dec_pc,             32'd0);
    check({tag, "_instr"}, bus.dec_instr,          32'd0);
    check({tag, "_empty"}, {31'd0, bus.empty},     32'd1);
    check({tag, "_full"},  {31'd0, bus.full},      32'd0);
  endtask

  // One clock cycle: drive at negedge, compare at negedge+1, advance the model at posedge.
  task automatic step();
    bit          drain, byp, rsp, keep, took_bypass;
    logic [31:0] e_pc, e_instr;
    req_t        r;
    @(negedge clk);
    bus.imem_ready  = ($urandom_range(99) < p_ready);
    bus.dec_ready   = ($urandom_range(99) < p_dec);
    bus.redirect    = f_redir ? 1'b1 : ($urandom_range(99) < p_redir);
    bus.redirect_pc = f_redir ? f_pc : $urandom;
    bus.imem_rvalid = bogus || (inflight.size() > 0 && inflight[0].issued < cyc
                                && $urandom_range(99) < p_rsp);
    bus.imem_rdata  = (bus.imem_rvalid && inflight.size() > 0) ? instr_of(inflight[0].addr)
                                                                 : $urandom;
    #1;
    drain = 1'b0;
    foreach (inflight[i]) if (inflight[i].stale) drain = 1'b1;
    m_req = !bus.redirect && !drain && (fifo.size() + inflight.size() < DEPTH)
            && (inflight.size() < MAX_OUT);
    byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (fifo.size() == 0) && !drain && !bus.redirect && bus.imem_rvalid && (inflight.size() > 0);
`endif
    m_dec_valid = (fifo.size() > 0) || byp;
    e_pc    = (fifo.size() > 0) ? fifo[0].pc    : byp ? inflight[0].addr : 32'd0;
    e_instr = (fifo.size() > 0) ? fifo[0].instr : byp ? bus.imem_rdata   : 32'd0;
    check("imem_req",  {31'd0, bus.imem_req},  {31'd0, m_req});
    check("imem_addr", bus.imem_addr,          fetch_pc);
    check("dec_valid", {31'd0, bus.dec_valid}, {31'd0, m_dec_valid});
    check("dec_pc",    bus.dec_pc,             e_pc);
    check("dec_instr", bus.dec_instr,          e_instr);
    check("empty",     {31'd0, bus.empty},     {31'd0, fifo.size() == 0});
    check("full",      {31'd0, bus.full},      {31'd0, fifo.size() == DEPTH});
    obs_valid = bus.dec_valid;
    obs_pc    = bus.dec_pc;

    @(posedge clk);
    rsp  = bus.imem_rvalid && (inflight.size() > 0);
    keep = 1'b0;
    if (rsp) begin
      r    = inflight.pop_front();
      keep = !r.stale && !bus.redirect;
    end
    took_bypass = 1'b0;
    if (m_dec_valid && bus.dec_ready) begin
      decoded++;
      if (fifo.size() > 0) void'(fifo.pop_front());
      else took_bypass = 1'b1;
    end
    if (keep && !took_bypass) fifo.push_back('{pc: r.addr, instr: bus.imem_rdata});
    if (m_req && bus.imem_ready) begin
      inflight.push_back('{addr: fetch_pc, issued: cyc, stale: 1'b0});
      fetch_pc += 32'd4;
    end
    if (bus.redirect) begin
      fifo.delete();
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      fetch_pc = bus.redirect_pc & ~32'h3;
    end
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    n_checks = 0; n_pass = 0; cyc = 0; decoded = 0;
    bogus = 1'b0; f_redir = 1'b0; f_pc = '0;
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    #2 check_reset("reset_init");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Warm-up: always-ready memory with 1-cycle latency and always-ready decode.
    p_ready = 100; p_rsp = 100; p_dec = 100; p_redir = 0;
    for (int i = 0; i < 10; i++) step();
    d0 = decoded;
    for (int i = 0; i < 20; i++) step();
    check("steady_throughput", decoded - d0, 32'd20);

    // Decode back-pressure until the FIFO fills, then release.
    p_dec = 0;
    for (int i = 0; i < 10; i++) step();
    check("backpressure_full", {31'd0, bus.full}, 32'd1);
    p_dec = 100;
    for (int i = 0; i < 20; i++) step();

    // Fill again and hit reset asynchronously between clock edges.
    p_dec = 0;
    for (int i = 0; i < 10; i++) step();
    check("prereset_full", {31'd0, bus.full}, 32'd1);
    #3;
    rst_n = 1'b0;
    drive_idle();
    #1 check_reset("reset_async");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Late responses from before reset arrive with nothing outstanding.
    p_ready = 0; p_rsp = 0; p_dec = 100; bogus = 1'b1;
    for (int i = 0; i < 3; i++) step();
    bogus = 1'b0;

    // Two requests in flight, redirect to 0x103, then redirect again to 0x300 while draining.
    p_ready = 100; p_rsp = 0; p_dec = 0;
    for (int i = 0; i < 8 && inflight.size() < MAX_OUT; i++) step();
    check("fill_inflight", inflight.size(), MAX_OUT);
    f_redir = 1'b1; f_pc = 32'h0000_0103;
    step();
    f_redir = 1'b0;
    step();
    check("drain_addr", bus.imem_addr, 32'h0000_0100);
    f_redir = 1'b1; f_pc = 32'h0000_0300;
    step();
    f_redir = 1'b0; p_rsp = 100; p_dec = 100;
    obs_valid = 1'b0;
    for (int i = 0; i < 20 && !obs_valid; i++) step();
    check("redirect_first_valid", {31'd0, obs_valid}, 32'd1);
    check("redirect_first_pc",    obs_pc,             32'h0000_0300);

    // Long random run with variable latency, stalls and occasional redirects.
    p_ready = 70; p_rsp = 60; p_dec = 60; p_redir = 4;
    for (int i = 0; i < 1500; i++) step();
    p_redir = 0; p_rsp = 100; p_dec = 100;
    for (int i = 0; i < 20; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
